// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a clock-enable pixel divider and a 3-bit test pattern.
// Every output is registered and decoded from next-state, so it describes the current (h,v).
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   CLK_DIV  = 2,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CHK_LOG2 = 4,
    parameter int   X_W      = 10,
    parameter int   Y_W      = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [1:0]     pattern_sel,
    output logic           pix_ce,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           de,
    output logic           hsync,
    output logic           vsync,
    output logic           line_start,
    output logic           frame_start,
    output logic [2:0]     pixel
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [X_W-1:0]   H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0]   V_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [X_W-1:0]   H_ACT    = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]   V_ACT    = Y_W'(V_ACTIVE);
    localparam logic [X_W-1:0]   HS_BEG   = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0]   HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [Y_W-1:0]   VS_BEG   = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0]   VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [X_W-1:0]   BAR_LAST = X_W'(BAR_W - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [X_W-1:0]   h_q, h_d, bar_cnt_q, bar_cnt_d, x_q, x_d;
    logic [Y_W-1:0]   v_q, v_d, y_q, y_d;
    logic [2:0]       bar_idx_q, bar_idx_d, pixel_q, pixel_d;
    logic [7:0]       frame_q, frame_d;
    logic             tick, de_q, de_d, hs_q, hs_d, vs_q, vs_d;
    logic             pix_ce_q, line_start_q, frame_start_q;

    always_comb begin
        tick      = en && (div_q == DIV_LAST);
        div_d     = div_q;
        h_d       = h_q;
        v_d       = v_q;
        bar_idx_d = bar_idx_q;
        bar_cnt_d = bar_cnt_q;
        frame_d   = frame_q;
        if (en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
        if (tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
            // Bar index restarts each line; leftover pixels past 8 bars stay in bar 7.
            if (h_d == '0) begin
                bar_idx_d = '0;
                bar_cnt_d = '0;
            end else if (bar_cnt_q == BAR_LAST) begin
                bar_cnt_d = '0;
                if (bar_idx_q != 3'd7) begin
                    bar_idx_d = bar_idx_q + 1'b1;
                end
            end else begin
                bar_cnt_d = bar_cnt_q + 1'b1;
            end
            if (h_d == '0 && v_d == '0) begin
                frame_d = frame_q + 1'b1;
            end
        end

        de_d = (h_d < H_ACT) && (v_d < V_ACT);
        hs_d = (h_d >= HS_BEG && h_d <= HS_END) ? HS_POL : ~HS_POL;
        vs_d = (v_d >= VS_BEG && v_d <= VS_END) ? VS_POL : ~VS_POL;
        x_d  = de_d ? h_d : '0;
        y_d  = de_d ? v_d : '0;
        pixel_d = 3'b000;
        if (de_d) begin
            case (pattern_sel)
                2'd1:    pixel_d = bar_idx_d;
                2'd2:    pixel_d = {3{h_d[CHK_LOG2] ^ v_d[CHK_LOG2]}};
                2'd3:    pixel_d = frame_d[2:0];
                default: pixel_d = 3'b000;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q         <= '0;
            h_q           <= H_LAST;
            v_q           <= V_LAST;
            bar_idx_q     <= '0;
            bar_cnt_q     <= '0;
            frame_q       <= '0;
            pix_ce_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            de_q          <= 1'b0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            x_q           <= '0;
            y_q           <= '0;
            pixel_q       <= '0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            bar_idx_q     <= bar_idx_d;
            bar_cnt_q     <= bar_cnt_d;
            frame_q       <= frame_d;
            pix_ce_q      <= tick;
            line_start_q  <= tick && (h_d == '0);
            frame_start_q <= tick && (h_d == '0) && (v_d == '0);
            // Level outputs move only with the counters so pattern_sel waits for the next pixel.
            if (tick) begin
                de_q    <= de_d;
                hs_q    <= hs_d;
                vs_q    <= vs_d;
                x_q     <= x_d;
                y_q     <= y_d;
                pixel_q <= pixel_d;
            end
        end
    end

    assign pix_ce      = pix_ce_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign de          = de_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign x           = x_q;
    assign y           = y_q;
    assign pixel       = pixel_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 14x8 raster: divide-by-1 and divide-by-3 instances.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, rst_b, en_b;
    logic [1:0] pattern_sel;
    logic       pix_ce, de, hsync, vsync, line_start, frame_start;
    logic [3:0] x, y;
    logic [2:0] pixel;
    logic       pix_ce_b, de_b, hsync_b, vsync_b, line_start_b, frame_start_b;
    logic [3:0] x_b, y_b;
    logic [2:0] pixel_b;

    int checks   = 0;
    int failures = 0;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(1), .HS_POL(1'b0), .VS_POL(1'b0), .CHK_LOG2(1), .X_W(4), .Y_W(4)
    ) u_dut (
        .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel),
        .pix_ce(pix_ce), .x(x), .y(y), .de(de), .hsync(hsync), .vsync(vsync),
        .line_start(line_start), .frame_start(frame_start), .pixel(pixel)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(3), .HS_POL(1'b0), .VS_POL(1'b0), .CHK_LOG2(1), .X_W(4), .Y_W(4)
    ) u_dut_div3 (
        .clk(clk), .rst(rst_b), .en(en_b), .pattern_sel(pattern_sel),
        .pix_ce(pix_ce_b), .x(x_b), .y(y_b), .de(de_b), .hsync(hsync_b), .vsync(vsync_b),
        .line_start(line_start_b), .frame_start(frame_start_b), .pixel(pixel_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; rst_b = 1'b1; en_b = 1'b1; pattern_sel = 2'd0;
        repeat (3) step();
        checks++; if (pix_ce !== 1'b0) begin failures++; $display("FAIL reset_pix_ce got=%0b exp=0", pix_ce); end
        checks++; if (de !== 1'b0) begin failures++; $display("FAIL reset_de got=%0b exp=0", de); end
        checks++; if (x !== 4'd0 || y !== 4'd0) begin failures++; $display("FAIL reset_xy got=%0d,%0d exp=0,0", x, y); end
        checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin failures++; $display("FAIL reset_sync got=%0b%0b exp=11", hsync, vsync); end
        checks++; if (line_start !== 1'b0 || frame_start !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%0b%0b exp=00", line_start, frame_start); end
        checks++; if (pixel !== 3'd0) begin failures++; $display("FAIL reset_pixel got=%0d exp=0", pixel); end
    endtask

    task automatic test_first_frame();
        int n;
        rst = 1'b0;
        step();
        checks++; if (frame_start !== 1'b1 || line_start !== 1'b1) begin failures++; $display("FAIL first_pulses got=%0b%0b exp=11", frame_start, line_start); end
        checks++; if (de !== 1'b1 || x !== 4'd0 || y !== 4'd0 || pix_ce !== 1'b1) begin
            failures++; $display("FAIL first_pos got de=%0b x=%0d y=%0d ce=%0b exp de=1 x=0 y=0 ce=1", de, x, y, pix_ce); end
        n = 0;
        do begin step(); n++; end while (frame_start !== 1'b1 && n < 300);
        checks++; if (n != 112) begin failures++; $display("FAIL frame_period got=%0d exp=112", n); end
    endtask

    task automatic test_line_timing();
        int de_l0 = 0, hs_l0 = 0, hs_first = -1, ls_cnt = 0, ls_gap_bad = 0, last_ls = -1;
        int vs_cnt = 0, vs_first = -1, fs_cnt = 0;
        logic [3:0] x3 = 0, x33 = 0, y33 = 0, x57 = 0;
        logic de57 = 1'b1;
        for (int i = 0; i < 112; i++) begin
            if (i < 14 && de) de_l0++;
            if (i < 14 && !hsync) begin hs_l0++; if (hs_first < 0) hs_first = i; end
            if (line_start) begin
                if (last_ls >= 0 && i - last_ls != 14) ls_gap_bad++;
                last_ls = i; ls_cnt++;
            end
            if (!vsync) begin vs_cnt++; if (vs_first < 0) vs_first = i; end
            if (frame_start) fs_cnt++;
            if (i == 3) x3 = x;
            if (i == 33) begin x33 = x; y33 = y; end
            if (i == 57) begin x57 = x; de57 = de; end
            step();
        end
        checks++; if (de_l0 != 8) begin failures++; $display("FAIL de_per_line got=%0d exp=8", de_l0); end
        checks++; if (hs_l0 != 3 || hs_first != 10) begin failures++; $display("FAIL hsync_window got=%0d@%0d exp=3@10", hs_l0, hs_first); end
        checks++; if (ls_cnt != 8 || ls_gap_bad != 0) begin failures++; $display("FAIL line_start got=%0d bad_gaps=%0d exp=8 bad_gaps=0", ls_cnt, ls_gap_bad); end
        checks++; if (vs_cnt != 28 || vs_first != 70) begin failures++; $display("FAIL vsync_window got=%0d@%0d exp=28@70", vs_cnt, vs_first); end
        checks++; if (fs_cnt != 1 || frame_start !== 1'b1) begin failures++; $display("FAIL frame_start got=%0d end=%0b exp=1 end=1", fs_cnt, frame_start); end
        checks++; if (x3 !== 4'd3 || x33 !== 4'd5 || y33 !== 4'd2) begin failures++; $display("FAIL coords got=%0d %0d,%0d exp=3 5,2", x3, x33, y33); end
        checks++; if (de57 !== 1'b0 || x57 !== 4'd0) begin failures++; $display("FAIL vblank got de=%0b x=%0d exp de=0 x=0", de57, x57); end
    endtask

    task automatic test_patterns();
        logic [2:0] exp_pix;
        pattern_sel = 2'd1;
        repeat (112) step();
        for (int h = 0; h < 14; h++) begin
            exp_pix = (h < 8) ? 3'(h) : 3'd0;
            checks++; if (pixel !== exp_pix) begin failures++; $display("FAIL bars h=%0d got=%0d exp=%0d", h, pixel, exp_pix); end
            step();
        end
        pattern_sel = 2'd3;
        repeat (98) step();
        for (int k = 0; k < 5; k++) begin
            exp_pix = 3'((5 + k) % 8);
            checks++; if (frame_start !== 1'b1 || pixel !== exp_pix) begin
                failures++; $display("FAIL frame_fill k=%0d got fs=%0b pix=%0d exp fs=1 pix=%0d", k, frame_start, pixel, exp_pix); end
            repeat (112) step();
        end
        pattern_sel = 2'd2;
        step();
        checks++; if (pixel !== 3'd0) begin failures++; $display("FAIL checker_1_0 got=%0d exp=0", pixel); end
        step();
        checks++; if (pixel !== 3'd7) begin failures++; $display("FAIL checker_2_0 got=%0d exp=7", pixel); end
        repeat (8) step();
        checks++; if (pixel !== 3'd0 || de !== 1'b0) begin failures++; $display("FAIL checker_blank got=%0d de=%0b exp=0 de=0", pixel, de); end
    endtask

    task automatic test_en_freeze();
        int n = 0, bad = 0, xbad = 0;
        logic [3:0] y0;
        while (!(de === 1'b1 && x === 4'd5) && n < 100) begin step(); n++; end
        checks++; if (n >= 100) begin failures++; $display("FAIL freeze_reach got=timeout exp=x5"); end
        y0 = y;
        en = 1'b0;
        repeat (20) begin
            step();
            if (pix_ce || line_start || frame_start) bad++;
            if (x !== 4'd5 || y !== y0 || de !== 1'b1) xbad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL freeze_pulses got=%0d exp=0", bad); end
        checks++; if (xbad != 0) begin failures++; $display("FAIL freeze_hold got=%0d exp=0", xbad); end
        en = 1'b1;
        step();
        checks++; if (x !== 4'd6 || y !== y0 || pix_ce !== 1'b1) begin
            failures++; $display("FAIL resume got x=%0d y=%0d ce=%0b exp x=6 y=%0d ce=1", x, y, pix_ce, y0); end
    endtask

    task automatic test_div3();
        int n = 0, m = 0, ce_cnt = 0, ls_cnt = 0, viol = 0, gap_bad = 0, last_ce = 0;
        logic [3:0] px, py;
        logic [2:0] ppix;
        logic pde, phs, pvs;
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        do begin step(); n++; end while (pix_ce_b !== 1'b1 && n < 20);
        checks++; if (n != 3) begin failures++; $display("FAIL div3_first_ce got=%0d exp=3", n); end
        checks++; if (frame_start_b !== 1'b1 || de_b !== 1'b1 || x_b !== 4'd0) begin
            failures++; $display("FAIL div3_first got fs=%0b de=%0b x=%0d exp fs=1 de=1 x=0", frame_start_b, de_b, x_b); end
        px = x_b; py = y_b; ppix = pixel_b; pde = de_b; phs = hsync_b; pvs = vsync_b;
        do begin
            step(); m++;
            if (pix_ce_b) begin
                ce_cnt++;
                if (m - last_ce != 3) gap_bad++;
                last_ce = m;
            end
            if (line_start_b) ls_cnt++;
            if (!pix_ce_b && (x_b !== px || y_b !== py || pixel_b !== ppix || de_b !== pde ||
                              hsync_b !== phs || vsync_b !== pvs || line_start_b || frame_start_b)) viol++;
            px = x_b; py = y_b; ppix = pixel_b; pde = de_b; phs = hsync_b; pvs = vsync_b;
        end while (frame_start_b !== 1'b1 && m < 1000);
        checks++; if (m != 336) begin failures++; $display("FAIL div3_frame got=%0d exp=336", m); end
        checks++; if (ce_cnt != 112 || gap_bad != 0) begin failures++; $display("FAIL div3_ce got=%0d bad_gaps=%0d exp=112 bad_gaps=0", ce_cnt, gap_bad); end
        checks++; if (ls_cnt != 8) begin failures++; $display("FAIL div3_lines got=%0d exp=8", ls_cnt); end
        checks++; if (viol != 0) begin failures++; $display("FAIL div3_change_off_ce got=%0d exp=0", viol); end
    endtask

    task automatic test_reset_vsync();
        int n = 0;
        pattern_sel = 2'd3;
        while (vsync !== 1'b0 && n < 200) begin step(); n++; end
        checks++; if (n >= 200) begin failures++; $display("FAIL rstv_reach got=timeout exp=vsync"); end
        rst = 1'b1;
        #1;
        checks++; if (vsync !== 1'b1 || hsync !== 1'b1 || de !== 1'b0 || pixel !== 3'd0) begin
            failures++; $display("FAIL rstv_async got vs=%0b hs=%0b de=%0b pix=%0d exp 1 1 0 0", vsync, hsync, de, pixel); end
        step();
        rst = 1'b0;
        step();
        checks++; if (frame_start !== 1'b1 || line_start !== 1'b1 || de !== 1'b1 || x !== 4'd0 || y !== 4'd0) begin
            failures++; $display("FAIL rstv_restart got fs=%0b ls=%0b de=%0b x=%0d y=%0d exp 1 1 1 0 0", frame_start, line_start, de, x, y); end
        checks++; if (pixel !== 3'd1) begin failures++; $display("FAIL rstv_frame_cnt got=%0d exp=1", pixel); end
        n = 0;
        do begin step(); n++; end while (frame_start !== 1'b1 && n < 300);
        checks++; if (n != 112) begin failures++; $display("FAIL rstv_period got=%0d exp=112", n); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_line_timing();
        test_patterns();
        test_en_freeze();
        test_div3();
        test_reset_vsync();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
